// File: rtl/axis_width_pack.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : axis_width_pack
//  Description : AXI-Stream width packer. Gathers R = OWIDTH/IWIDTH narrow
//                beats into one wide word (first beat in lane 0). A word is
//                closed early by tlast; unfilled lanes carry zero data and
//                zero keep. One accumulator plus one registered output word,
//                latency one cycle, full throughput under m_axis_tready=1.
//                IWIDTH must be a multiple of 8 and OWIDTH a multiple of
//                IWIDTH with at least two lanes.
//  Revision    : 1.0 - initial release
// ============================================================================
module axis_width_pack #(
    parameter int IWIDTH = 32,
    parameter int OWIDTH = 256
) (
    input  logic                clk,
    input  logic                resetn,
    // narrow input stream
    input  logic                s_axis_tvalid,
    output logic                s_axis_tready,
    input  logic [IWIDTH-1:0]   s_axis_tdata,
    input  logic [IWIDTH/8-1:0] s_axis_tkeep,
    input  logic                s_axis_tlast,
    // wide output stream
    output logic                m_axis_tvalid,
    input  logic                m_axis_tready,
    output logic [OWIDTH-1:0]   m_axis_tdata,
    output logic [OWIDTH/8-1:0] m_axis_tkeep,
    output logic                m_axis_tlast
);

    localparam int c_lanes   = OWIDTH / IWIDTH;
    localparam int c_ikeep_w = IWIDTH / 8;
    localparam int c_okeep_w = OWIDTH / 8;
    localparam int c_cnt_w   = $clog2(c_lanes);
    localparam logic [c_cnt_w-1:0] c_last_lane = c_cnt_w'(c_lanes - 1);

    // ACC: filling the accumulator. HOLD: accumulator holds a finished
    // (tlast-terminated) word that could not move because the output is busy.
    typedef enum logic [0:0] {
        ST_ACC  = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    state_t                r_state;
    state_t                w_state_next;

    logic [c_cnt_w-1:0]    r_cnt;
    logic [OWIDTH-1:0]     r_acc_data;
    logic [c_okeep_w-1:0]  r_acc_keep;
    logic                  r_acc_last;

    logic                  r_out_valid;
    logic [OWIDTH-1:0]     r_out_data;
    logic [c_okeep_w-1:0]  r_out_keep;
    logic                  r_out_last;

    logic                  w_out_free;
    logic                  w_s_ready;
    logic                  w_accept;
    logic                  w_load_out;
    logic                  w_enter_hold;
    logic [OWIDTH-1:0]     w_merge_data;
    logic [c_okeep_w-1:0]  w_merge_keep;
    logic                  w_merge_last;

    // The output register can take a new word if it is empty or draining now.
    assign w_out_free = ~r_out_valid | m_axis_tready;
    assign w_accept   = s_axis_tvalid & w_s_ready;

    // State register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= ST_ACC;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state, input ready and datapath control. Ready depends only on
    // state, lane count and the output side, never on the input beat.
    always_comb begin
        w_state_next = r_state;
        w_s_ready    = 1'b0;
        w_load_out   = 1'b0;
        w_enter_hold = 1'b0;
        case (r_state)
            ST_ACC: begin
                w_s_ready = (r_cnt != c_last_lane) | w_out_free;
                if (s_axis_tvalid && w_s_ready &&
                    ((r_cnt == c_last_lane) || s_axis_tlast)) begin
                    if (w_out_free) begin
                        w_load_out = 1'b1;
                    end else begin
                        // only reachable for an early tlast: lane R-1 waits
                        // for out_free before it is accepted at all
                        w_enter_hold = 1'b1;
                        w_state_next = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                if (w_out_free) begin
                    w_load_out   = 1'b1;
                    w_state_next = ST_ACC;
                end
            end
            default: begin
                w_state_next = ST_ACC;
            end
        endcase
    end

    // Accumulator contents with the current beat (if accepted) in lane cnt.
    always_comb begin
        w_merge_data = r_acc_data;
        w_merge_keep = r_acc_keep;
        for (int k = 0; k < c_lanes; k++) begin
            if (w_accept && (r_cnt == c_cnt_w'(k))) begin
                w_merge_data[k*IWIDTH +: IWIDTH]       = s_axis_tdata;
                w_merge_keep[k*c_ikeep_w +: c_ikeep_w] = s_axis_tkeep;
            end
        end
        w_merge_last = w_accept ? s_axis_tlast : r_acc_last;
    end

    // Accumulator, lane counter and output word register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_cnt       <= '0;
            r_acc_data  <= '0;
            r_acc_keep  <= '0;
            r_acc_last  <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_keep  <= '0;
            r_out_last  <= 1'b0;
        end else begin
            if (w_load_out) begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_merge_data;
                r_out_keep  <= w_merge_keep;
                r_out_last  <= w_merge_last;
                r_acc_data  <= '0;
                r_acc_keep  <= '0;
                r_acc_last  <= 1'b0;
                r_cnt       <= '0;
            end else begin
                if (r_out_valid && m_axis_tready) begin
                    r_out_valid <= 1'b0;
                end
                if (w_accept) begin
                    r_acc_data <= w_merge_data;
                    r_acc_keep <= w_merge_keep;
                    r_acc_last <= w_merge_last;
                    // lane count freezes while the finished word waits
                    if (!w_enter_hold) begin
                        r_cnt <= r_cnt + c_cnt_w'(1);
                    end
                end
            end
        end
    end

    assign s_axis_tready = w_s_ready;
    assign m_axis_tvalid = r_out_valid;
    assign m_axis_tdata  = r_out_data;
    assign m_axis_tkeep  = r_out_keep;
    assign m_axis_tlast  = r_out_last;

endmodule
`default_nettype wire

// File: tb/tb_axis_width_pack.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_axis_width_pack
//  Description : Self-checking bench for axis_width_pack (32 -> 256 bits).
//                Directed scenarios followed by random traffic; a queue-based
//                reference model predicts packed words, valid and ready.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_axis_width_pack;

    localparam int IW  = 32;
    localparam int OW  = 256;
    localparam int R   = OW / IW;
    localparam int KW  = IW / 8;
    localparam int OKW = OW / 8;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic          s_axis_tvalid = 1'b0;
    logic          s_axis_tready;
    logic [IW-1:0] s_axis_tdata = '0;
    logic [KW-1:0] s_axis_tkeep = '0;
    logic          s_axis_tlast = 1'b0;
    logic          m_axis_tvalid;
    logic          m_axis_tready;
    logic [OW-1:0] m_axis_tdata;
    logic [OKW-1:0] m_axis_tkeep;
    logic          m_axis_tlast;

    logic          mready_dir  = 1'b1;
    logic          mready_rnd  = 1'b1;
    logic          mready_rand = 1'b0;
    assign m_axis_tready = mready_rand ? mready_rnd : mready_dir;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [OW-1:0]  data;
        logic [OKW-1:0] keep;
        logic           last;
    } word_t;

    word_t         exp_q[$];
    logic [IW-1:0] part_d[$];
    logic [KW-1:0] part_k[$];

    always #5 clk = ~clk;

    axis_width_pack #(.IWIDTH(IW), .OWIDTH(OW)) dut (
        .clk           (clk),
        .resetn        (resetn),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tkeep  (s_axis_tkeep),
        .s_axis_tlast  (s_axis_tlast),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tkeep  (m_axis_tkeep),
        .m_axis_tlast  (m_axis_tlast)
    );

    task automatic check(input string name, input logic [OW-1:0] act, input logic [OW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Random downstream ready, used only in the random phase.
    always @(negedge clk) begin
        mready_rnd <= ($urandom_range(0, 99) < 60);
    end

    // Monitor: sampled late in the low phase, just before each rising edge.
    // Reference model: at most one word in the output slot plus one finished
    // word waiting, so ready/valid follow from the number of words owed.
    initial begin : monitor
        word_t          w;
        logic           stall_prev;
        logic [OW-1:0]  pd;
        logic [OKW-1:0] pk;
        logic           pl;
        logic           out_free_m;
        logic           ready_exp;
        stall_prev = 1'b0;
        forever begin
            @(negedge clk);
            #4;
            if (!resetn) begin
                part_d.delete();
                part_k.delete();
                exp_q.delete();
                stall_prev = 1'b0;
            end else begin
                out_free_m = (exp_q.size() == 0) || m_axis_tready;
                ready_exp  = (exp_q.size() < 2) && ((part_d.size() != R - 1) || out_free_m);
                check("s_tready", OW'(s_axis_tready), OW'(ready_exp));
                check("m_tvalid", OW'(m_axis_tvalid), OW'(exp_q.size() != 0));
                if (stall_prev) begin
                    check("stall_data", m_axis_tdata, pd);
                    check("stall_keep", OW'(m_axis_tkeep), OW'(pk));
                    check("stall_last", OW'(m_axis_tlast), OW'(pl));
                end
                if (m_axis_tvalid && m_axis_tready && exp_q.size() != 0) begin
                    w = exp_q.pop_front();
                    check("word_data", m_axis_tdata, w.data);
                    check("word_keep", OW'(m_axis_tkeep), OW'(w.keep));
                    check("word_last", OW'(m_axis_tlast), OW'(w.last));
                end
                if (s_axis_tvalid && s_axis_tready) begin
                    part_d.push_back(s_axis_tdata);
                    part_k.push_back(s_axis_tkeep);
                    if (part_d.size() == R || s_axis_tlast) begin
                        w.data = '0;
                        w.keep = '0;
                        w.last = s_axis_tlast;
                        for (int k = 0; k < part_d.size(); k++) begin
                            w.data[k*IW +: IW] = part_d[k];
                            w.keep[k*KW +: KW] = part_k[k];
                        end
                        exp_q.push_back(w);
                        part_d.delete();
                        part_k.delete();
                    end
                end
                stall_prev = m_axis_tvalid && !m_axis_tready;
                pd = m_axis_tdata;
                pk = m_axis_tkeep;
                pl = m_axis_tlast;
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Offer one beat from a falling edge until accepted (bounded wait).
    task automatic send_beat(input logic [IW-1:0] d, input logic [KW-1:0] k, input logic l);
        int  waitc;
        logic acc;
        waitc = 0;
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = d;
        s_axis_tkeep  = k;
        s_axis_tlast  = l;
        while (1) begin
            #4;
            acc = s_axis_tready;
            @(negedge clk);
            if (acc) break;
            waitc++;
            if (waitc > 200) begin
                checks++;
                failures++;
                $display("FAIL send_timeout actual=not_accepted required=accepted data=%h", d);
                break;
            end
        end
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_m_tvalid"}, OW'(m_axis_tvalid), '0);
        check({tag, "_m_tdata"},  m_axis_tdata, '0);
        check({tag, "_m_tkeep"},  OW'(m_axis_tkeep), '0);
        check({tag, "_m_tlast"},  OW'(m_axis_tlast), '0);
        check({tag, "_s_tready"}, OW'(s_axis_tready), OW'(1'b1));
    endtask

    initial begin : stimulus
        logic [OW-1:0] exp_w;
        int            waitc;

        // reset state
        #1;
        check_reset_outputs("reset");
        idle(2);
        resetn = 1'b1;
        idle(1);

        // full word A0..A7, tlast on the 8th
        mready_dir = 1'b1;
        for (int i = 0; i < R; i++) send_beat(IW'(32'hA0 + i), 4'hF, (i == R - 1));
        #1;
        exp_w = '0;
        for (int i = 0; i < R; i++) exp_w[i*IW +: IW] = IW'(32'hA0 + i);
        check("full_data", m_axis_tdata, exp_w);
        check("full_keep", OW'(m_axis_tkeep), OW'(32'hFFFF_FFFF));
        check("full_last", OW'(m_axis_tlast), OW'(1'b1));
        idle(1);

        // short packet 1,2,3 then a following packet starting in lane 0
        for (int i = 1; i <= 3; i++) send_beat(IW'(i), 4'hF, (i == 3));
        #1;
        exp_w = '0;
        exp_w[95:0] = 96'h00000003_00000002_00000001;
        check("short_data", m_axis_tdata, exp_w);
        check("short_keep", OW'(m_axis_tkeep), OW'(32'h0000_0FFF));
        check("short_last", OW'(m_axis_tlast), OW'(1'b1));
        idle(1);
        send_beat(32'h55, 4'h3, 1'b1);
        #1;
        check("lane0_data", m_axis_tdata, OW'(32'h55));
        check("lane0_keep", OW'(m_axis_tkeep), OW'(4'h3));
        idle(2);

        // backpressure: 16 beats against a stalled output
        mready_dir = 1'b0;
        fork
            for (int i = 0; i < 2 * R; i++) send_beat(IW'(32'h100 + i), 4'hF, 1'b0);
            begin
                idle(25);
                mready_dir = 1'b1;
            end
        join
        idle(3);

        // HOLD: output occupied, early tlast finishes the accumulator
        mready_dir = 1'b0;
        for (int i = 0; i < R; i++) send_beat(IW'(32'h200 + i), 4'hF, 1'b0);
        send_beat(32'h300, 4'hF, 1'b0);
        send_beat(32'h301, 4'hF, 1'b1);
        idle(3);
        mready_dir = 1'b1;
        idle(1);
        mready_dir = 1'b0;
        #1;
        exp_w = '0;
        exp_w[63:0] = 64'h00000301_00000300;
        check("hold_data", m_axis_tdata, exp_w);
        check("hold_keep", OW'(m_axis_tkeep), OW'(32'h0000_00FF));
        check("hold_last", OW'(m_axis_tlast), OW'(1'b1));
        check("hold_s_tready", OW'(s_axis_tready), OW'(1'b1));
        idle(2);
        mready_dir = 1'b1;
        idle(2);

        // reset mid-word: 5 beats then reset, then 8 fresh beats
        for (int i = 0; i < 5; i++) send_beat(IW'(32'hDEAD_0000 + i), 4'hF, 1'b0);
        mready_dir = 1'b0;
        #1;
        resetn = 1'b0;
        #1;
        check_reset_outputs("midreset");
        @(negedge clk);
        resetn = 1'b1;
        mready_dir = 1'b1;
        idle(1);
        for (int i = 0; i < R; i++) send_beat(IW'(32'hB0 + i), 4'hF, (i == R - 1));
        #1;
        exp_w = '0;
        for (int i = 0; i < R; i++) exp_w[i*IW +: IW] = IW'(32'hB0 + i);
        check("fresh_data", m_axis_tdata, exp_w);
        idle(2);

        // streaming: 64 back-to-back beats
        for (int i = 0; i < 64; i++) send_beat(IW'(32'h1000 + i), 4'hF, ((i % R) == R - 1));
        idle(2);

        // random traffic with random downstream ready
        mready_rand = 1'b1;
        for (int i = 0; i < 500; i++) begin
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
            send_beat($urandom, KW'($urandom_range(1, 15)), ($urandom_range(0, 5) == 0));
        end
        mready_rand = 1'b0;
        mready_dir  = 1'b1;

        // drain
        waitc = 0;
        while (exp_q.size() != 0 && waitc < 100) begin
            @(negedge clk);
            waitc++;
        end
        check("drain_empty", OW'(exp_q.size()), '0);
        idle(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
